// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus between the calculator control FSM and seq_divider.
// The control FSM uses the master modport and the divider uses the slave modport.
interface seq_divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider producing one quotient bit per clock, with a start/busy/done handshake.
// Optional macro SIGNED_DIV_EN selects two's-complement operands with truncation toward zero.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_reg_q, q_reg_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] r_src;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] dvd_in;
    logic [WIDTH-1:0] dvs_in;
    logic             accept;

`ifdef SIGNED_DIV_EN
    logic q_neg_q, q_neg_d;
    logic r_neg_q, r_neg_d;
`endif

    // The partial remainder is always below the divisor, so WIDTH bits hold it and the
    // WIDTH+1-bit shifted value covers a divisor with its MSB set; trial[WIDTH] is the borrow.
    always_comb begin
        r_shift = {r_q, q_reg_q[WIDTH-1]};
        trial   = r_shift - {1'b0, d_q};
        r_src   = (d_q == '0) ? q_reg_q : r_q;
`ifdef SIGNED_DIV_EN
        dvd_in  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        dvs_in  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
        q_res   = q_neg_q ? -q_reg_q : q_reg_q;
        r_res   = r_neg_q ? -r_src   : r_src;
`else
        dvd_in  = bus.dividend;
        dvs_in  = bus.divisor;
        q_res   = q_reg_q;
        r_res   = r_src;
`endif
    end

    // A start arriving during the done cycle is still busy and therefore ignored.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        q_reg_d     = q_reg_q;
        d_d         = d_q;
        r_d         = r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
        accept      = 1'b0;
`ifdef SIGNED_DIV_EN
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
`endif

        case (state_q)
            IDLE: begin
                accept = bus.start && !busy_q;
                if (accept) begin
                    q_reg_d = dvd_in;
                    d_d     = dvs_in;
                    r_d     = '0;
                    cnt_d   = CW'(WIDTH);
                    dbz_d   = 1'b0;
`ifdef SIGNED_DIV_EN
                    q_neg_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    r_neg_d = bus.dividend[WIDTH-1];
`endif
                    state_d = (bus.divisor == '0) ? DONE : CALC;
                end
            end

            CALC: begin
                if (trial[WIDTH]) begin
                    r_d = r_shift[WIDTH-1:0];
                end else begin
                    r_d = trial[WIDTH-1:0];
                end
                q_reg_d = {q_reg_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (d_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = r_res;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = q_res;
                    remainder_d = r_res;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE) || done_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            q_reg_q     <= '0;
            d_q         <= '0;
            r_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SIGNED_DIV_EN
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_reg_q     <= q_reg_d;
            d_q         <= d_d;
            r_q         <= r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
`ifdef SIGNED_DIV_EN
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed literal cases plus random traffic against an arithmetic model.
// Honours SIGNED_DIV_EN in the same way as the design.
module tb_seq_divider;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seq_divider_if #(.WIDTH(W)) bus();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int         cyc = 0;
    int         done_edge = 0;
    bit         started = 0;
    bit         pending = 0;
    bit         prev_busy;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic         m_dbz = 1'b0;
    logic [W-1:0] p_q, p_r;
    logic         p_z;

    // Arithmetic reference: native division, truncation toward zero in the signed build.
    function automatic void modelDiv(input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] q, output logic [W-1:0] r,
                                     output logic z);
        int sa, sb, iq, ir;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef SIGNED_DIV_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'({16'd0, a});
            sb = int'({16'd0, b});
`endif
            iq = sa / sb;
            ir = sa % sb;
            q  = iq[W-1:0];
            r  = ir[W-1:0];
            z  = 1'b0;
        end
    endfunction

    // Cycle-level expectation: busy from acceptance through the done cycle, results at the done edge.
    always @(posedge clk) begin
        cyc++;
        started = 1;
        prev_busy = m_busy;
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_q     = '0;
            m_r     = '0;
            m_dbz   = 1'b0;
            pending = 0;
        end else begin
            m_done = 1'b0;
            if (pending && cyc == done_edge) begin
                m_done = 1'b1;
                m_q    = p_q;
                m_r    = p_r;
                m_dbz  = p_z;
            end
            if (bus.start && !prev_busy) begin
                modelDiv(bus.dividend, bus.divisor, p_q, p_r, p_z);
                m_dbz     = 1'b0;
                done_edge = cyc + ((bus.divisor == '0) ? 1 : W + 1);
                pending   = 1;
            end
            m_busy = pending && (cyc <= done_edge);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            n_checks++;
            if (bus.busy !== m_busy || bus.done !== m_done || bus.quotient !== m_q ||
                bus.remainder !== m_r || bus.div_by_zero !== m_dbz) begin
                n_errors++;
                if (n_errors <= 30)
                    $display("[TB] FAIL model cycle %0d: got busy=%b done=%b q=%h r=%h dbz=%b, expected busy=%b done=%b q=%h r=%h dbz=%b",
                             cyc, bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero,
                             m_busy, m_done, m_q, m_r, m_dbz);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
    endtask

    task automatic waitIdle();
        int k = 0;
        while (bus.busy && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        checkOutput("idle before start", {31'd0, bus.busy}, 32'd0);
    endtask

    // Accepts one division, then scrambles the operand inputs to show they are not needed afterwards.
    task automatic runDivision(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                               input logic exp_z, input int exp_lat);
        int n = 0;
        bit seen = 0;
        waitIdle();
        applyStimulus(a, b);
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
        checkOutput({tag, " busy after accept"}, {31'd0, bus.busy}, 32'd1);
        while (n < 40 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (bus.done) seen = 1;
        end
        checkOutput({tag, " latency"}, n, exp_lat);
        checkOutput({tag, " quotient"}, {16'd0, bus.quotient}, {16'd0, exp_q});
        checkOutput({tag, " remainder"}, {16'd0, bus.remainder}, {16'd0, exp_r});
        checkOutput({tag, " div_by_zero"}, {31'd0, bus.div_by_zero}, {31'd0, exp_z});
        @(posedge clk); #1;
        checkOutput({tag, " done one cycle"}, {31'd0, bus.done}, 32'd0);
        checkOutput({tag, " busy released"}, {31'd0, bus.busy}, 32'd0);
        checkOutput({tag, " quotient held"}, {16'd0, bus.quotient}, {16'd0, exp_q});
    endtask

    initial begin
        int ndone, lat;
        logic [W-1:0] cq, cr;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset done", {31'd0, bus.done}, 32'd0);
        checkOutput("reset quotient", {16'd0, bus.quotient}, 32'd0);
        checkOutput("reset remainder", {16'd0, bus.remainder}, 32'd0);
        checkOutput("reset div_by_zero", {31'd0, bus.div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        runDivision("100/7",       16'd100,  16'd7,      16'd14,     16'd2,  1'b0, 17);
        runDivision("FFFF/1",      16'hFFFF, 16'd1,      16'hFFFF,   16'd0,  1'b0, 17);
        runDivision("3/8001",      16'd3,    16'h8001,   16'd0,      16'd3,  1'b0, 17);
        runDivision("0/9",         16'd0,    16'd9,      16'd0,      16'd0,  1'b0, 17);
        runDivision("5/0",         16'd5,    16'd0,      16'hFFFF,   16'd5,  1'b1, 1);
        runDivision("9/3",         16'd9,    16'd3,      16'd3,      16'd0,  1'b0, 17);

        // Second start in the middle of a division must be dropped.
        waitIdle();
        applyStimulus(16'd1000, 16'd10);
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0;
        lat = 0;
        cq = '0;
        cr = '0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 5) applyStimulus(16'd7, 16'd7);
            if (k == 6) bus.start = 1'b0;
            @(posedge clk); #1;
            if (bus.done) begin
                ndone++;
                if (lat == 0) lat = k;
                cq = bus.quotient;
                cr = bus.remainder;
            end
        end
        checkOutput("ignored start done count", ndone, 1);
        checkOutput("ignored start latency", lat, 17);
        checkOutput("ignored start quotient", {16'd0, cq}, 32'd100);
        checkOutput("ignored start remainder", {16'd0, cr}, 32'd0);

        // Reset in the middle of a division aborts it silently.
        waitIdle();
        applyStimulus(16'd50000, 16'd3);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("abort done", {31'd0, bus.done}, 32'd0);
        checkOutput("abort quotient", {16'd0, bus.quotient}, 32'd0);
        checkOutput("abort remainder", {16'd0, bus.remainder}, 32'd0);
        checkOutput("abort div_by_zero", {31'd0, bus.div_by_zero}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        checkOutput("abort no done pulse", ndone, 0);
`ifdef SIGNED_DIV_EN
        runDivision("50000/3",     16'd50000, 16'd3,     16'hEBC6,   16'hFFFE, 1'b0, 17);
        runDivision("-7/2",        16'hFFF9,  16'd2,     16'hFFFD,   16'hFFFF, 1'b0, 17);
        runDivision("7/-2",        16'd7,     16'hFFFE,  16'hFFFD,   16'd1,    1'b0, 17);
        runDivision("8000/FFFF",   16'h8000,  16'hFFFF,  16'h8000,   16'd0,    1'b0, 17);
        runDivision("-5/0",        16'hFFFB,  16'd0,     16'hFFFF,   16'hFFFB, 1'b1, 1);
`else
        runDivision("50000/3",     16'd50000, 16'd3,     16'd16666,  16'd2,    1'b0, 17);
        runDivision("8000/FFFF",   16'h8000,  16'hFFFF,  16'd0,      16'h8000, 1'b0, 17);
`endif

        // Random traffic, including held and mid-flight starts, zero and MSB-set divisors.
        for (int k = 0; k < 4000; k++) begin
            bus.start    = ($urandom_range(0, 3) == 0);
            bus.dividend = W'($urandom);
            case ($urandom_range(0, 4))
                0:       bus.divisor = '0;
                1:       bus.divisor = W'($urandom_range(1, 15));
                2:       bus.divisor = W'($urandom) | 16'h8000;
                3:       bus.divisor = 16'hFFFF;
                default: bus.divisor = W'($urandom);
            endcase
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        repeat (25) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider for the calculator datapath. It is the divide counterpart of the AND-array partial-product multiplier.
- Unsigned WIDTH-bit dividend / divisor produces a quotient and remainder.
- Shift-subtract, one quotient bit per clock.
- Start/busy/done handshake toward the calculator control FSM.

Parameters:
WIDTH, 16, operand, quotient and remainder width in bits (>= 2)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  request a division; sampled only in IDLE
dividend  input  WIDTH  numerator; sampled with start
divisor  input  WIDTH  denominator; sampled with start
busy  output  1  high while a division is in progress (CALC or DONE state)
done  output  1  single-cycle pulse: results valid
quotient  output  WIDTH  result quotient; held until next accepted start
remainder  output  WIDTH  result remainder; held until next accepted start
div_by_zero  output  1  set with done when divisor == 0; held with results

Behaviour:
- Reset (rst_n == 0 at a clock edge):
  - State returns to IDLE.
  - busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0.
  - Iteration counter = 0.
  - Reset mid-operation aborts the division with no done pulse.
- States: IDLE, CALC, DONE.
- IDLE:
  - busy = 0.
  - On start = 1: latch dividend into the shift register Q, latch divisor into D, clear partial remainder R (WIDTH+1 bits), load counter = WIDTH.
  - Clear div_by_zero on acceptance.
  - If divisor != 0, go to CALC. If divisor == 0, go to DONE directly.
- CALC, one iteration per cycle:
  - {R,Q} shifted left by 1.
  - T = R_shifted - {0,D}.
  - If T is non-negative: R = T and Q[0] = 1. Otherwise R = R_shifted and Q[0] = 0.
  - Counter decrements. After the iteration with counter == 1, go to DONE.
  - Exactly WIDTH cycles in CALC.
- DONE, one cycle:
  - Normal case: quotient <= Q, remainder <= R[WIDTH-1:0], done = 1.
  - Divide-by-zero case: quotient <= all ones, remainder <= latched dividend, div_by_zero <= 1, done = 1.
  - Next state is IDLE.
- Latency, with start sampled at edge N:
  - Normal divide: done = 1 during the cycle after edge N+WIDTH+1, i.e. results visible WIDTH+1 edges after acceptance (17 for WIDTH=16).
  - Divide-by-zero: done visible after edge N+1.
- busy rises the cycle after acceptance and falls together with the done pulse ending (back in IDLE).
- start while busy is ignored: no restart, in-flight operands unaffected, no queuing.
- start held high continuously: a new division is accepted on the first IDLE cycle after each DONE.
- Operand inputs may change freely after acceptance.
- Outputs are registered; no combinational path from inputs to outputs.
- Arithmetic rules:
  - Unsigned.
  - dividend < divisor gives quotient 0, remainder = dividend.
  - dividend == 0 gives 0 / 0.
  - Trial subtract is WIDTH+1 bits wide, so a divisor with MSB set works correctly.

Optional Feature:
Macro SIGNED_DIV_EN.
- Defined: operands are two's complement.
  - Magnitudes are taken at acceptance.
  - The unsigned core runs unchanged.
  - In DONE, quotient is negated when the operand signs differ, and remainder takes the sign of the dividend (truncation toward zero).
  - Latency unchanged.
  - Divide-by-zero: quotient = all ones, remainder = dividend.
  - Most-negative / -1 (0x8000 / 0xFFFF): quotient = 0x8000, remainder = 0, no flag.
- Not defined: purely unsigned as above; no sign logic synthesized.

Test Plan:
- 100 / 7 (WIDTH=16), start one cycle:
  - Quotient 14, remainder 2, div_by_zero 0.
  - done high exactly 17 edges after acceptance, for one cycle.
  - busy high in between.
- 0xFFFF / 1 gives 0xFFFF, remainder 0. 0x0003 / 0x8001 gives quotient 0, remainder 3.
- 5 / 0: done after 1 edge, quotient 0xFFFF, remainder 5, div_by_zero 1. The next valid division (9/3) clears the flag and yields 3, remainder 0.
- 1000 / 10 started, then start pulsed with 7 / 7 at cycle 5: second request ignored; result 100, remainder 0; a single done pulse.
- 50000 / 3 started, rst_n low at cycle 8:
  - All outputs 0 on the next edge and no done pulse.
  - After release, 50000 / 3 gives 16666, remainder 2.
- SIGNED_DIV_EN defined:
  - -7 / 2 gives 0xFFFD (-3), remainder 0xFFFF (-1).
  - 7 / -2 gives 0xFFFD, remainder 1.
  - 0x8000 / 0xFFFF gives 0x8000, remainder 0.
